axi4_lite_gpu: RTL and testbench
================================

Name: axi4_lite_gpu

Overview:
AXI4-Lite slave control front-end of the GPU. It decodes register reads and pixel/clear command writes. Pixel commands become single-cycle write strobes on a write-only framebuffer BRAM port. It sits between the PS AXI interconnect and the framebuffer BRAM.

Parameters:
- AXI_ADDRESS_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 32, AXI data width.
- FBUF_ADDR_WIDTH, 19, framebuffer pixel address width.
- FBUF_DATA_WIDTH, 8, framebuffer pixel width.
- Constraint: FBUF_ADDR_WIDTH + FBUF_DATA_WIDTH <= AXI_DATA_WIDTH.

Ports:
- s_axi_ctrl_aclk  in  1  sole clock; all logic on rising edge.
- s_axi_ctrl_areset  in  1  asynchronous, active-high reset.
- s_axi_ctrl_araddr  in  AXI_ADDRESS_WIDTH  read address.
- s_axi_ctrl_arvalid / s_axi_ctrl_arready  in / out  1  AR handshake.
- s_axi_ctrl_rdata  out  AXI_DATA_WIDTH  read data.
- s_axi_ctrl_rresp  out  2  read response.
- s_axi_ctrl_rvalid / s_axi_ctrl_rready  out / in  1  R handshake.
- s_axi_ctrl_awaddr  in  AXI_ADDRESS_WIDTH  write address.
- s_axi_ctrl_awvalid / s_axi_ctrl_awready  in / out  1  AW handshake.
- s_axi_ctrl_wdata  in  AXI_DATA_WIDTH  write data (no strobes; full-word writes).
- s_axi_ctrl_wvalid / s_axi_ctrl_wready  in / out  1  W handshake.
- s_axi_ctrl_bresp  out  2  write response.
- s_axi_ctrl_bvalid / s_axi_ctrl_bready  out / in  1  B handshake.
- fbuf_en_wr  out  1  BRAM port enable.
- fbuf_wrea  out  1  BRAM write enable.
- fbuf_addr  out  FBUF_ADDR_WIDTH  pixel address.
- fbuf_data  out  FBUF_DATA_WIDTH  pixel value.
- fbuf_rst_req_n  out  1  active-low framebuffer clear request.

Behaviour:
- Reset (async assert, sync release):
  - All READY/VALID low; rdata, rresp, bresp, fbuf_addr, fbuf_data, fbuf_en_wr and fbuf_wrea all 0.
  - fbuf_rst_req_n held 0 during reset.
  - Pending transactions are discarded.
  - A ready_en flop goes to 1 at the first clock edge after release; all READYs are gated by ready_en.
- Register map (word address; any addr[1:0] != 0 or addr >= 0x08 is an error):
  - 0x00 read INFO: returns FBUF_DATA_WIDTH zero-extended (8 at defaults).
  - 0x00 write PIXEL: fbuf_data = wdata[FBUF_DATA_WIDTH-1:0]; fbuf_addr = wdata[FBUF_DATA_WIDTH +: FBUF_ADDR_WIDTH]; upper bits ignored.
  - 0x04 read LAST_CMD: last accepted PIXEL wdata; reset value 0.
  - 0x04 write CLEAR: wdata[0]=1 drives fbuf_rst_req_n low for exactly one cycle; wdata[0]=0 is a no-op with OKAY.
  - Error read: RRESP=2'b10 (SLVERR), RDATA=0xFFFFFFFF. Error write: BRESP=2'b10, no side effects. Otherwise RESP=2'b00.
- Read path, two stages:
  - Stage S1 captures araddr on the AR handshake.
  - At the next edge, S1 moves to the output register (RVALID=1 with RDATA/RRESP), provided the output is empty or being consumed that edge.
  - ARREADY = ready_en && !(S1 full && RVALID).
  - RVALID, RDATA and RRESP stay stable until the R handshake edge; RVALID falls at that edge unless S1 refills it.
  - Latency: AR handshake at edge N gives RVALID from edge N+1.
- Write path:
  - Capture flags aw_held and w_held plus one execute slot.
  - AWREADY = WREADY = ready_en && !(aw_held && w_held).
  - One outstanding write is supported: a repeated AW before its W (or W before AW) overwrites the held value. Masters must not do this.
  - Pair completes (both captured; AW and W may arrive on the same edge) and execute slot empty: at that same edge the command enters execute and the capture flags clear.
  - Execute, cycle 1: PIXEL drives fbuf_en_wr=fbuf_wrea=1 for one cycle with fbuf_addr/data loaded and updates LAST_CMD; CLEAR pulses fbuf_rst_req_n; an error write produces no strobe.
  - Execute, next edge: BVALID=1 with BRESP, held until the B handshake edge; the execute slot frees at that edge.
  - A pair that completes while execute is busy waits in capture, so both READYs are low until it drains.
  - fbuf_addr/fbuf_data hold their last value between writes.
- Reads and writes are independent and may overlap.

Test Plan:
- Reset 10 cycles, then release → ARREADY/AWREADY/WREADY and RVALID/BVALID low throughout reset; fbuf_rst_req_n=0 during reset and 1 afterwards.
- AR 0x00 for one cycle → ARREADY high the cycle after; RVALID by the 2nd edge, RDATA=8, RRESP=00; RREADY 1 cycle → RVALID low next cycle.
- AR 0x01 → RRESP=10, RDATA=0xFFFFFFFF; same timing as above.
- AW 0x00, then W 0x0078_0FE3 the next cycle → AWREADY and WREADY high; one-cycle fbuf_en_wr=fbuf_wrea=1 with fbuf_addr=0x0780F, fbuf_data=0xE3; BVALID with BRESP=00 within 3 cycles; BREADY → BVALID low; read 0x04 returns 0x00780FE3.
- AW and W same cycle at 0x04 with data 1 → one-cycle fbuf_rst_req_n=0, BRESP=00. AW at 0x10 → BRESP=10, no fbuf strobe.
- Hold BREADY=0 and issue a second AW+W → second pair captured, READYs low; no second strobe until the first B handshake, then it executes.

Source files
------------

// File: rtl/axi4_lite_gpu.sv
// axi4_lite_gpu: AXI4-Lite register front-end turning pixel/clear writes into framebuffer BRAM strobes.
module axi4_lite_gpu #(
   parameter int AXI_ADDRESS_WIDTH = 32,
   parameter int AXI_DATA_WIDTH    = 32,
   parameter int FBUF_ADDR_WIDTH   = 19,
   parameter int FBUF_DATA_WIDTH   = 8
) (
   input  logic                         s_axi_ctrl_aclk,
   input  logic                         s_axi_ctrl_areset,
   input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_araddr,
   input  logic                         s_axi_ctrl_arvalid,
   output logic                         s_axi_ctrl_arready,
   output logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_rdata,
   output logic [1:0]                   s_axi_ctrl_rresp,
   output logic                         s_axi_ctrl_rvalid,
   input  logic                         s_axi_ctrl_rready,
   input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_awaddr,
   input  logic                         s_axi_ctrl_awvalid,
   output logic                         s_axi_ctrl_awready,
   input  logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_wdata,
   input  logic                         s_axi_ctrl_wvalid,
   output logic                         s_axi_ctrl_wready,
   output logic [1:0]                   s_axi_ctrl_bresp,
   output logic                         s_axi_ctrl_bvalid,
   input  logic                         s_axi_ctrl_bready,
   output logic                         fbuf_en_wr,
   output logic                         fbuf_wrea,
   output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
   output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data,
   output logic                         fbuf_rst_req_n
);
   logic                         ready_en;
   logic                         s1_full;
   logic [AXI_ADDRESS_WIDTH-1:0] s1_addr;
   logic [AXI_DATA_WIDTH-1:0]    last_cmd;
   logic                         aw_held, w_held, ex_busy;
   logic [AXI_ADDRESS_WIDTH-1:0] aw_addr;
   logic [AXI_DATA_WIDTH-1:0]    w_data;
   logic ar_hs, r_hs, r_move, r_err, aw_hs, w_hs, b_hs, enter, w_err;
   logic [AXI_ADDRESS_WIDTH-1:0] addr_n;
   logic [AXI_DATA_WIDTH-1:0]    data_n;
   assign s_axi_ctrl_arready = ready_en && !(s1_full && s_axi_ctrl_rvalid);
   assign s_axi_ctrl_awready = ready_en && !(aw_held && w_held);
   assign s_axi_ctrl_wready  = s_axi_ctrl_awready;
   assign ar_hs  = s_axi_ctrl_arvalid && s_axi_ctrl_arready;
   assign r_hs   = s_axi_ctrl_rvalid && s_axi_ctrl_rready;
   assign r_move = s1_full && (!s_axi_ctrl_rvalid || r_hs);
   assign r_err  = (s1_addr[1:0] != 2'b00) || (s1_addr >= AXI_ADDRESS_WIDTH'(8));
   assign aw_hs  = s_axi_ctrl_awvalid && s_axi_ctrl_awready;
   assign w_hs   = s_axi_ctrl_wvalid && s_axi_ctrl_wready;
   assign b_hs   = s_axi_ctrl_bvalid && s_axi_ctrl_bready;
   // Same-edge AW/W arrivals bypass the capture registers so the pair can execute immediately.
   assign addr_n = aw_hs ? s_axi_ctrl_awaddr : aw_addr;
   assign data_n = w_hs ? s_axi_ctrl_wdata : w_data;
   assign enter  = (aw_held || aw_hs) && (w_held || w_hs) && !ex_busy;
   assign w_err  = (addr_n[1:0] != 2'b00) || (addr_n >= AXI_ADDRESS_WIDTH'(8));
   always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
      if (s_axi_ctrl_areset) begin
         ready_en          <= 1'b0;
         s1_full           <= 1'b0;
         s1_addr           <= '0;
         s_axi_ctrl_rvalid <= 1'b0;
         s_axi_ctrl_rdata  <= '0;
         s_axi_ctrl_rresp  <= 2'b00;
      end else begin
         ready_en <= 1'b1;
         if (ar_hs) begin
            s1_full <= 1'b1;
            s1_addr <= s_axi_ctrl_araddr;
         end else if (r_move) begin
            s1_full <= 1'b0;
         end
         if (r_move) begin
            s_axi_ctrl_rvalid <= 1'b1;
            s_axi_ctrl_rresp  <= r_err ? 2'b10 : 2'b00;
            s_axi_ctrl_rdata  <= r_err ? '1 : s1_addr[2] ? last_cmd : AXI_DATA_WIDTH'(FBUF_DATA_WIDTH);
         end else if (r_hs) begin
            s_axi_ctrl_rvalid <= 1'b0;
         end
      end
   end
   always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
      if (s_axi_ctrl_areset) begin
         aw_held           <= 1'b0;
         w_held            <= 1'b0;
         aw_addr           <= '0;
         w_data            <= '0;
         ex_busy           <= 1'b0;
         last_cmd          <= '0;
         s_axi_ctrl_bvalid <= 1'b0;
         s_axi_ctrl_bresp  <= 2'b00;
         fbuf_en_wr        <= 1'b0;
         fbuf_wrea         <= 1'b0;
         fbuf_addr         <= '0;
         fbuf_data         <= '0;
         fbuf_rst_req_n    <= 1'b0;
      end else begin
         fbuf_en_wr     <= enter && !w_err && !addr_n[2];
         fbuf_wrea      <= enter && !w_err && !addr_n[2];
         fbuf_rst_req_n <= !(enter && !w_err && addr_n[2] && data_n[0]);
         if (enter) begin
            aw_held          <= 1'b0;
            w_held           <= 1'b0;
            ex_busy          <= 1'b1;
            s_axi_ctrl_bresp <= w_err ? 2'b10 : 2'b00;
            if (!w_err && !addr_n[2]) begin
               fbuf_data <= data_n[FBUF_DATA_WIDTH-1:0];
               fbuf_addr <= data_n[FBUF_DATA_WIDTH +: FBUF_ADDR_WIDTH];
               last_cmd  <= data_n;
            end
         end else begin
            if (aw_hs) begin
               aw_held <= 1'b1;
               aw_addr <= s_axi_ctrl_awaddr;
            end
            if (w_hs) begin
               w_held <= 1'b1;
               w_data <= s_axi_ctrl_wdata;
            end
         end
         if (b_hs) begin
            s_axi_ctrl_bvalid <= 1'b0;
            ex_busy           <= 1'b0;
         end else if (ex_busy && !s_axi_ctrl_bvalid) begin
            s_axi_ctrl_bvalid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_axi4_lite_gpu.sv
// tb_axi4_lite_gpu: table-driven register reads/writes plus reset and back-pressure sequences.
module tb_axi4_lite_gpu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic        arready, rvalid, awready, wready, bvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;
   logic        fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n;
   logic [18:0] fbuf_addr;
   logic [7:0]  fbuf_data;
   int n_vec = 0, n_bad = 0;
   int strobes = 0, clr_cycles = 0, wrea_bad = 0;
   int s0, c0;
   logic [18:0] last_faddr = '0;
   logic [7:0]  last_fdata = '0;

   axi4_lite_gpu dut (
      .s_axi_ctrl_aclk(clk), .s_axi_ctrl_areset(rst),
      .s_axi_ctrl_araddr(araddr), .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready),
      .s_axi_ctrl_rdata(rdata), .s_axi_ctrl_rresp(rresp), .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready),
      .s_axi_ctrl_awaddr(awaddr), .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready),
      .s_axi_ctrl_wdata(wdata), .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wready(wready),
      .s_axi_ctrl_bresp(bresp), .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready),
      .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr),
      .fbuf_data(fbuf_data), .fbuf_rst_req_n(fbuf_rst_req_n)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!rst) begin
      if (fbuf_en_wr) begin
         strobes++;
         last_faddr = fbuf_addr;
         last_fdata = fbuf_data;
      end
      if (fbuf_en_wr !== fbuf_wrea) wrea_bad++;
      if (!fbuf_rst_req_n) clr_cycles++;
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          gap;
      int          strobe;
      int          clr;
      logic [18:0] faddr;
      logic [7:0]  fdata;
      logic [1:0]  bresp;
      logic [31:0] last;
   } wr_vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er, input string tag);
      bit hs;
      int n = 0;
      araddr  = a;
      arvalid = 1'b1;
      do begin
         hs = arready;
         tick();
         n++;
      end while (!hs && n < 20);
      arvalid = 1'b0;
      chk({tag, "_ar_hs"}, 32'(hs), 32'd1);
      chk({tag, "_rvalid_early"}, 32'(rvalid), 32'd0);
      tick();
      chk({tag, "_rvalid_lat"}, 32'(rvalid), 32'd1);
      chk({tag, "_rdata"}, rdata, ed);
      chk({tag, "_rresp"}, 32'(rresp), 32'(er));
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
   endtask

   task automatic wait_b(input string tag);
      int n = 0;
      while (!bvalid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
   endtask

   task automatic do_write(input wr_vec_t v, input string tag);
      bit aw_hs, w_hs, aw_done = 0, w_done = 0;
      int n = 0;
      s0 = strobes;
      c0 = clr_cycles;
      awaddr  = v.addr;
      awvalid = 1'b1;
      wdata   = v.data;
      wvalid  = !v.gap;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         n++;
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
         if (w_hs) begin wvalid = 1'b0; w_done = 1; end
         if (aw_done && !w_done && !wvalid) wvalid = 1'b1;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wait_b(tag);
      chk({tag, "_bresp"}, 32'(bresp), 32'(v.bresp));
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
      chk({tag, "_strobes"}, 32'(strobes - s0), 32'(v.strobe));
      chk({tag, "_clr_cycles"}, 32'(clr_cycles - c0), 32'(v.clr));
      chk({tag, "_fbuf_addr"}, 32'(fbuf_addr), 32'(v.faddr));
      chk({tag, "_fbuf_data"}, 32'(fbuf_data), 32'(v.fdata));
      do_read(32'h4, v.last, 2'b00, {tag, "_last"});
   endtask

   rd_vec_t rv[5];
   wr_vec_t wv[6];

   initial begin
      rv[0] = '{32'h00, 32'h0000_0008, 2'b00};
      rv[1] = '{32'h01, 32'hFFFF_FFFF, 2'b10};
      rv[2] = '{32'h04, 32'h0000_0000, 2'b00};
      rv[3] = '{32'h08, 32'hFFFF_FFFF, 2'b10};
      rv[4] = '{32'h06, 32'hFFFF_FFFF, 2'b10};
      wv[0] = '{32'h00, 32'h0078_0FE3, 1'b1, 1, 0, 19'h0780F, 8'hE3, 2'b00, 32'h0078_0FE3};
      wv[1] = '{32'h04, 32'h0000_0001, 1'b0, 0, 1, 19'h0780F, 8'hE3, 2'b00, 32'h0078_0FE3};
      wv[2] = '{32'h04, 32'h0000_0000, 1'b0, 0, 0, 19'h0780F, 8'hE3, 2'b00, 32'h0078_0FE3};
      wv[3] = '{32'h10, 32'h0000_1234, 1'b0, 0, 0, 19'h0780F, 8'hE3, 2'b10, 32'h0078_0FE3};
      wv[4] = '{32'h02, 32'h0000_0055, 1'b1, 0, 0, 19'h0780F, 8'hE3, 2'b10, 32'h0078_0FE3};
      wv[5] = '{32'h00, 32'hFFFF_FFAA, 1'b0, 1, 0, 19'h7FFFF, 8'hAA, 2'b00, 32'hFFFF_FFAA};
      arvalid = 1'b1;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst_readys", {29'd0, arready, awready, wready}, 32'd0);
         chk("rst_valids_clr_n", {29'd0, rvalid, bvalid, fbuf_rst_req_n}, 32'd0);
      end
      arvalid = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      chk("post_rst_clr_n", 32'(fbuf_rst_req_n), 32'd1);
      chk("post_rst_readys", {29'd0, arready, awready, wready}, 32'd7);
      chk("post_rst_outputs", {fbuf_en_wr, fbuf_wrea, 11'd0, fbuf_addr}, 32'd0);
      foreach (rv[i]) do_read(rv[i].addr, rv[i].data, rv[i].resp, $sformatf("rd%0d", i));
      foreach (wv[i]) do_write(wv[i], $sformatf("wr%0d", i));
      // Back-pressure: second pair must wait in capture until the first B handshake.
      s0 = strobes;
      awaddr = 32'h0; wdata = 32'h0012_3456; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      wait_b("bp_first");
      chk("bp_first_strobe", 32'(strobes - s0), 32'd1);
      chk("bp_first_addr", 32'(last_faddr), 32'h0_1234);
      awaddr = 32'h0; wdata = 32'h0065_4321; awvalid = 1'b1; wvalid = 1'b1;
      chk("bp_second_ready", {30'd0, awready, wready}, 32'd3);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("bp_blocked_readys", {30'd0, awready, wready}, 32'd0);
      chk("bp_no_second_strobe", 32'(strobes - s0), 32'd1);
      chk("bp_bvalid_held", 32'(bvalid), 32'd1);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      wait_b("bp_second");
      chk("bp_second_strobe", 32'(strobes - s0), 32'd2);
      chk("bp_second_addr", 32'(last_faddr), 32'h0_6543);
      chk("bp_second_data", 32'(last_fdata), 32'h21);
      chk("bp_second_bresp", 32'(bresp), 32'd0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("bp_bvalid_drop", 32'(bvalid), 32'd0);
      chk("bp_readys_back", {30'd0, awready, wready}, 32'd3);
      chk("wrea_matches_en", 32'(wrea_bad), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
